// File: rtl/pg_switch_resp.sv
// Power-switch responder: turns en_pw_sw into a staggered thermometer ramp of
// header-switch segment enables and acknowledges full-on / full-off on sw_ack.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_ON      | all segments enabled, sw_ack=1
// S_RDN     | stepping segments off every D cycles, then one settle period
// S_OFF     | all segments disabled, sw_ack=0
// S_RUP     | stepping segments on every D cycles, then one settle period
module pg_switch_resp #(
  parameter int N_SEG = 8,
  parameter int DLY_W = 16,
  localparam int LW = $clog2(N_SEG + 1)
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             en_pw_sw,
  input  logic [DLY_W-1:0] seg_delay,
  output logic [N_SEG-1:0] seg_en,
  output logic             sw_ack,
  output logic [LW-1:0]    lvl,
  output logic             busy
);

  localparam logic [1:0] S_ON  = 2'd0;
  localparam logic [1:0] S_RDN = 2'd1;
  localparam logic [1:0] S_OFF = 2'd2;
  localparam logic [1:0] S_RUP = 2'd3;

  localparam logic [LW-1:0] LVL_MAX = LW'(N_SEG);

  logic [1:0]       state, state_nxt;
  logic [LW-1:0]    lvl_nxt, lvl_inc, lvl_dec;
  logic [DLY_W-1:0] cnt, cnt_nxt;
  logic [DLY_W-1:0] d_lat, d_nxt, d_cur;
  logic             step;
  logic [N_SEG-1:0] seg_nxt;
  logic             ack_nxt, busy_nxt;

  always_comb begin
    d_cur   = (seg_delay == '0) ? DLY_W'(1) : seg_delay;
    step    = (cnt == d_lat - DLY_W'(1));
    lvl_inc = (lvl == LVL_MAX) ? lvl : lvl + LW'(1);
    lvl_dec = (lvl == '0) ? lvl : lvl - LW'(1);
  end

  // Reversal requests are tested before the counter step so they win the cycle.
  always_comb begin
    state_nxt = state;
    lvl_nxt   = lvl;
    cnt_nxt   = cnt;
    d_nxt     = d_lat;
    case (state)
      S_ON: begin
        if (!en_pw_sw) begin
          state_nxt = S_RDN;
          lvl_nxt   = lvl_dec;
          cnt_nxt   = '0;
          d_nxt     = d_cur;
        end
      end
      S_RDN: begin
        if (en_pw_sw) begin
          state_nxt = S_RUP;
          lvl_nxt   = lvl_inc;
          cnt_nxt   = '0;
          d_nxt     = d_cur;
        end else if (step) begin
          cnt_nxt = '0;
          if (lvl != '0) lvl_nxt = lvl - LW'(1);
          else state_nxt = S_OFF;
        end else begin
          cnt_nxt = cnt + DLY_W'(1);
        end
      end
      S_OFF: begin
        if (en_pw_sw) begin
          state_nxt = S_RUP;
          lvl_nxt   = lvl_inc;
          cnt_nxt   = '0;
          d_nxt     = d_cur;
        end
      end
      S_RUP: begin
        if (!en_pw_sw) begin
          state_nxt = S_RDN;
          lvl_nxt   = lvl_dec;
          cnt_nxt   = '0;
          d_nxt     = d_cur;
        end else if (step) begin
          cnt_nxt = '0;
          if (lvl != LVL_MAX) lvl_nxt = lvl + LW'(1);
          else state_nxt = S_ON;
        end else begin
          cnt_nxt = cnt + DLY_W'(1);
        end
      end
      default: begin
        state_nxt = S_ON;
        lvl_nxt   = LVL_MAX;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    seg_nxt = '0;
    for (int i = 0; i < N_SEG; i++) seg_nxt[i] = (i < int'(lvl_nxt));
    ack_nxt  = (state_nxt == S_ON) || (state_nxt == S_RDN);
    busy_nxt = (state_nxt == S_RDN) || (state_nxt == S_RUP);
  end

  always_ff @(posedge ck) begin
    if (!rst) begin
      state  <= S_ON;
      lvl    <= LVL_MAX;
      cnt    <= '0;
      d_lat  <= DLY_W'(1);
      seg_en <= '1;
      sw_ack <= 1'b1;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      lvl    <= lvl_nxt;
      cnt    <= cnt_nxt;
      d_lat  <= d_nxt;
      seg_en <= seg_nxt;
      sw_ack <= ack_nxt;
      busy   <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_pg_switch_resp.sv
// Directed bench for pg_switch_resp with N_SEG=4: reset, both ramps, zero
// delay, reversals in both directions and a mid-ramp reset.
module tb_pg_switch_resp;

  localparam int N = 4;
  localparam int DW = 16;

  logic          ck = 1'b0;
  logic          rst = 1'b0;
  logic          en_pw_sw = 1'b1;
  logic [DW-1:0] seg_delay = 16'd3;
  logic [N-1:0]  seg_en;
  logic          sw_ack;
  logic [2:0]    lvl;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  pg_switch_resp #(.N_SEG(N), .DLY_W(DW)) dut (
    .ck(ck), .rst(rst), .en_pw_sw(en_pw_sw), .seg_delay(seg_delay),
    .seg_en(seg_en), .sw_ack(sw_ack), .lvl(lvl), .busy(busy)
  );

  always #5 ck = ~ck;

  // Advance one edge and sample 1 time unit after it.
  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en_pw_sw = 1'b1; seg_delay = 16'd3;
    step(); step();
    n_cmp++; if (seg_en !== 4'b1111) begin n_bad++; $display("FAIL reset_seg_en got %b want 1111", seg_en); end
    n_cmp++; if (sw_ack !== 1'b1) begin n_bad++; $display("FAIL reset_sw_ack got %b want 1", sw_ack); end
    n_cmp++; if (lvl !== 3'd4) begin n_bad++; $display("FAIL reset_lvl got %0d want 4", lvl); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b1;
    step();
    n_cmp++; if (seg_en !== 4'b1111 || busy !== 1'b0) begin n_bad++; $display("FAIL reset_hold_on seg_en=%b busy=%b want 1111/0", seg_en, busy); end
  endtask

  task automatic test_turn_off();
    logic [3:0] exp_seg [13] = '{4'b0111, 4'b0111, 4'b0111, 4'b0011, 4'b0011, 4'b0011,
                                 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    seg_delay = 16'd3; en_pw_sw = 1'b0;
    for (int k = 0; k < 13; k++) begin
      step();
      n_cmp++; if (seg_en !== exp_seg[k]) begin n_bad++; $display("FAIL off_seg_en[T+%0d] got %b want %b", k, seg_en, exp_seg[k]); end
      n_cmp++; if (sw_ack !== (k < 12)) begin n_bad++; $display("FAIL off_sw_ack[T+%0d] got %b want %b", k, sw_ack, (k < 12)); end
      n_cmp++; if (busy !== (k < 12)) begin n_bad++; $display("FAIL off_busy[T+%0d] got %b want %b", k, busy, (k < 12)); end
    end
    n_cmp++; if (lvl !== 3'd0) begin n_bad++; $display("FAIL off_lvl got %0d want 0", lvl); end
  endtask

  task automatic test_turn_on();
    logic [3:0] exp_seg [13] = '{4'b0001, 4'b0001, 4'b0001, 4'b0011, 4'b0011, 4'b0011,
                                 4'b0111, 4'b0111, 4'b0111, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
    logic [2:0] exp_lvl [13] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2,
                                 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4};
    seg_delay = 16'd3; en_pw_sw = 1'b1;
    for (int k = 0; k < 13; k++) begin
      step();
      if (k == 0) seg_delay = 16'd7;
      n_cmp++; if (seg_en !== exp_seg[k]) begin n_bad++; $display("FAIL on_seg_en[T+%0d] got %b want %b", k, seg_en, exp_seg[k]); end
      n_cmp++; if (lvl !== exp_lvl[k]) begin n_bad++; $display("FAIL on_lvl[T+%0d] got %0d want %0d", k, lvl, exp_lvl[k]); end
      n_cmp++; if (sw_ack !== (k >= 12)) begin n_bad++; $display("FAIL on_sw_ack[T+%0d] got %b want %b", k, sw_ack, (k >= 12)); end
      n_cmp++; if (busy !== (k < 12)) begin n_bad++; $display("FAIL on_busy[T+%0d] got %b want %b", k, busy, (k < 12)); end
    end
  endtask

  task automatic test_zero_delay();
    logic [3:0] exp_seg [5] = '{4'b0111, 4'b0011, 4'b0001, 4'b0000, 4'b0000};
    seg_delay = 16'd0; en_pw_sw = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      n_cmp++; if (seg_en !== exp_seg[k]) begin n_bad++; $display("FAIL zd_seg_en[T+%0d] got %b want %b", k, seg_en, exp_seg[k]); end
      n_cmp++; if (sw_ack !== (k < 4)) begin n_bad++; $display("FAIL zd_sw_ack[T+%0d] got %b want %b", k, sw_ack, (k < 4)); end
    end
  endtask

  task automatic test_reverse_down_to_up();
    logic [3:0] exp_seg [7] = '{4'b0111, 4'b0111, 4'b0111, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
    // From OFF, ramp on quickly with D=1: ON after 5 edges.
    seg_delay = 16'd1; en_pw_sw = 1'b1;
    repeat (5) step();
    n_cmp++; if (sw_ack !== 1'b1 || seg_en !== 4'b1111) begin n_bad++; $display("FAIL rev_prep_on sw_ack=%b seg_en=%b want 1/1111", sw_ack, seg_en); end
    seg_delay = 16'd3; en_pw_sw = 1'b0;
    repeat (4) step();
    n_cmp++; if (seg_en !== 4'b0011) begin n_bad++; $display("FAIL rev_prep_down seg_en got %b want 0011", seg_en); end
    en_pw_sw = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step();
      n_cmp++; if (seg_en !== exp_seg[k]) begin n_bad++; $display("FAIL rev_seg_en[+%0d] got %b want %b", k, seg_en, exp_seg[k]); end
      n_cmp++; if (sw_ack !== (k >= 6)) begin n_bad++; $display("FAIL rev_sw_ack[+%0d] got %b want %b", k, sw_ack, (k >= 6)); end
    end
  endtask

  task automatic test_reverse_up_settle();
    seg_delay = 16'd1; en_pw_sw = 1'b0;
    repeat (5) step();
    n_cmp++; if (sw_ack !== 1'b0 || lvl !== 3'd0) begin n_bad++; $display("FAIL rus_prep_off sw_ack=%b lvl=%0d want 0/0", sw_ack, lvl); end
    seg_delay = 16'd2; en_pw_sw = 1'b1;
    repeat (8) step();
    n_cmp++; if (seg_en !== 4'b1111 || sw_ack !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL rus_settle seg_en=%b sw_ack=%b busy=%b want 1111/0/1", seg_en, sw_ack, busy); end
    // Reversal lands on the same edge the settle period would end.
    en_pw_sw = 1'b0;
    step();
    n_cmp++; if (lvl !== 3'd3 || seg_en !== 4'b0111) begin n_bad++; $display("FAIL rus_rev lvl=%0d seg_en=%b want 3/0111", lvl, seg_en); end
    n_cmp++; if (sw_ack !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL rus_rev_flags sw_ack=%b busy=%b want 1/1", sw_ack, busy); end
    repeat (7) step();
    n_cmp++; if (sw_ack !== 1'b1 || lvl !== 3'd0) begin n_bad++; $display("FAIL rus_drain sw_ack=%b lvl=%0d want 1/0", sw_ack, lvl); end
    step();
    n_cmp++; if (sw_ack !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rus_off sw_ack=%b busy=%b want 0/0", sw_ack, busy); end
  endtask

  task automatic test_mid_reset();
    seg_delay = 16'd3; en_pw_sw = 1'b1;
    step();
    n_cmp++; if (seg_en !== 4'b0001 || busy !== 1'b1) begin n_bad++; $display("FAIL mr_ramp seg_en=%b busy=%b want 0001/1", seg_en, busy); end
    rst = 1'b0;
    step();
    n_cmp++; if (seg_en !== 4'b1111) begin n_bad++; $display("FAIL mr_seg_en got %b want 1111", seg_en); end
    n_cmp++; if (sw_ack !== 1'b1 || busy !== 1'b0 || lvl !== 3'd4) begin n_bad++; $display("FAIL mr_flags sw_ack=%b busy=%b lvl=%0d want 1/0/4", sw_ack, busy, lvl); end
    rst = 1'b1;
    repeat (3) step();
    n_cmp++; if (seg_en !== 4'b1111 || busy !== 1'b0) begin n_bad++; $display("FAIL mr_stay_on seg_en=%b busy=%b want 1111/0", seg_en, busy); end
  endtask

  initial begin
    #2;
    test_reset();
    test_turn_off();
    test_turn_on();
    test_zero_delay();
    test_reverse_down_to_up();
    test_reverse_up_settle();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pg_switch_resp.md
# pg_switch_resp

Power-switch responder for one gated power domain: the far end of the power-gating controller's `en_pw_sw`/`sw_ack` handshake. It turns a single enable request into a staggered, thermometer-coded ramp of header-switch segment enables, limiting in-rush current. It reports completion on `sw_ack`: high once the domain is fully on, low once it is fully off. It sits between the power-gating FSM and the physical switch cells of the gated domain.

## Interface
- `N_SEG`, default 8: number of switch segments, 2..32.
- `DLY_W`, default 16: width of the per-segment delay value.

Ports:
- `ck`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `en_pw_sw`  in  1  1 = request domain on, 0 = request domain off.
- `seg_delay`  in  `DLY_W`  cycles between successive segment steps; 0 is treated as 1.
- `seg_en`  out  `N_SEG`  segment enables, thermometer code, bit 0 switches first on and last off.
- `sw_ack`  out  1  1 = fully on or still draining, 0 = fully off or still ramping up.
- `lvl`  out  $clog2(`N_SEG`+1)  number of segments currently enabled.
- `busy`  out  1  1 while in RAMP_UP or RAMP_DOWN.

## Operation
- State register: ON, RAMP_DOWN, OFF, RAMP_UP. Level counter `lvl` ranges 0..`N_SEG`. `seg_en[i] = (i < lvl)`, registered.
- Delay counter `cnt` is `DLY_W` bits wide. The delay `D` = max(`seg_delay`,1) is latched on every ramp entry. Changing `seg_delay` mid-ramp has no effect.
- Reset (`rst`=0 at an edge), regardless of current state: state ON, `lvl`=`N_SEG`, `seg_en` all ones, `sw_ack`=1, `busy`=0, `cnt`=0. The domain powers up on, which matches the controller's reset state.
- ON:
  - `en_pw_sw`=0 → RAMP_DOWN; at that same edge `lvl` decrements, `cnt`=0, `D` latched.
  - Otherwise stay.
- RAMP_DOWN: `cnt` increments each cycle.
  - When `cnt`=D-1 and `lvl`>0: `lvl` decrements and `cnt`=0.
  - When `cnt`=D-1 and `lvl`=0 (settle period done): → OFF.
  - `sw_ack` stays 1 throughout.
- OFF: `sw_ack`=0, `lvl`=0.
  - `en_pw_sw`=1 → RAMP_UP; at that edge `lvl` increments, `cnt`=0, `D` latched.
- RAMP_UP: mirror of RAMP_DOWN.
  - `lvl` increments every D cycles up to `N_SEG`.
  - Once `lvl`=`N_SEG`, one further D-cycle settle period, then → ON and `sw_ack`=1.
  - `sw_ack` stays 0 throughout.
- Request reversal:
  - `en_pw_sw`=1 sampled in RAMP_DOWN → RAMP_UP at that edge. `lvl` increments, unless already `N_SEG`, in which case it holds. `cnt`=0, `D` relatched, `sw_ack`→0.
  - `en_pw_sw`=0 sampled in RAMP_UP → RAMP_DOWN at that edge. `lvl` decrements, unless already 0, in which case it holds. `cnt`=0, `sw_ack`→1.
- Reversal takes priority over the counter step in the same cycle.
- `lvl` never wraps: it saturates at 0 and at `N_SEG`.
- `busy` = 1 exactly in RAMP_UP and RAMP_DOWN.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Turn-off, with `en_pw_sw` falling and first sampled at edge T:
  - `seg_en[N_SEG-1-k]` clears at edge T+k·D, for k=0..`N_SEG`-1.
  - `sw_ack` falls at edge T+`N_SEG`·D.
- Turn-on, with `en_pw_sw` rising and first sampled at edge T:
  - `seg_en[k]` sets at edge T+k·D.
  - `sw_ack` rises at edge T+`N_SEG`·D.
- Total handshake latency: `N_SEG`·D cycles in each direction.
- At most one `seg_en` bit changes per edge.
- Protocol expected of the requester: hold `en_pw_sw` stable until `sw_ack` matches the request. Reversal behaviour is defined for robustness only.

## Test plan
- Reset: `rst`=0 for 2 cycles with `en_pw_sw`=1 → `seg_en`=all ones, `sw_ack`=1, `lvl`=`N_SEG`, `busy`=0.
- Turn-off, with `N_SEG`=4 and `seg_delay`=3: drop `en_pw_sw` at edge T → `seg_en` = 0111 at T, 0011 at T+3, 0001 at T+6, 0000 at T+9; `sw_ack` 1→0 at T+12; `busy` high from T to T+11.
- Turn-on from OFF, same parameters: raise `en_pw_sw` at edge T → `seg_en` = 0001, 0011, 0111, 1111 at T, T+3, T+6, T+9; `sw_ack` rises at T+12. Also change `seg_delay` to 7 at T+1 → no effect on this ramp.
- `seg_delay`=0 → behaves as 1: full off ramp with `N_SEG`=4 gives `sw_ack` falling 4 cycles after the request is sampled.
- Reversal: in RAMP_DOWN at `seg_en`=0011, raise `en_pw_sw` → `seg_en`=0111 at the same edge, `sw_ack`=0, then 1111 D cycles later, then `sw_ack`=1 after a further D cycles.
- Mid-ramp reset: assert `rst`=0 during RAMP_UP at `seg_en`=0001 → next edge gives `seg_en`=1111, `sw_ack`=1, state ON, `cnt`=0.
